// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: datapath width, execution
// units, opcodes, immediate formats and the operation codes sent to EXE.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_BRU = 2'd1,
        UNIT_LSU = 2'd2,
        UNIT_SYS = 2'd3
    } unit_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2
    } op2_sel_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Codes below are only meaningful together with the unit they travel with.
    // ALU ops otherwise use {instr[30], funct3}; 1011/1100 are unused there.
    localparam logic [3:0] OPE_LUI    = 4'b1011;
    localparam logic [3:0] OPE_AUIPC  = 4'b1100;
    // BRU: branches use {0, funct3}, so bit 3 marks the jumps.
    localparam logic [3:0] OPE_JAL    = 4'b1000;
    localparam logic [3:0] OPE_JALR   = 4'b1001;
    // SYS unit.
    localparam logic [3:0] OPE_ECALL  = 4'b0000;
    localparam logic [3:0] OPE_EBREAK = 4'b0001;
    localparam logic [3:0] OPE_FENCE  = 4'b0010;
    // LSU: loads use {0, funct3}; stores set bit 3.
    localparam logic [3:0] OPE_STORE_BIT = 4'b1000;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/decode_imm.sv
// Combinational RV32I immediate extractor: picks the bit layout for the
// requested format and sign-extends it to XLEN.
module decode_imm
    import riscv_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  imm_fmt_t        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    // Reassemble the scattered immediate fields of each format.
    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: classifies the fetched instruction, reads and forwards
// the source registers, builds the operands and registers one micro-op per
// cycle towards EXE. Startup bubbles and redirect cycles yield invalid uops.
module decode
    import riscv_pkg::*;
#(
    parameter int unsigned RESET_BUBBLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     instr_q_i,
    input  logic [XLEN-1:0] pc_q_i,
    input  logic            branch_v_q_i,
    input  logic            exception_q_i,
    output logic [4:0]      rf_adr1_o,
    output logic [4:0]      rf_adr2_o,
    input  logic [XLEN-1:0] rf_data1_i,
    input  logic [XLEN-1:0] rf_data2_i,
    input  logic            exe_rd_v_i,
    input  logic [4:0]      exe_rd_adr_i,
    input  logic [XLEN-1:0] exe_rd_data_i,
    output logic            valid_q_o,
    output logic [XLEN-1:0] pc_q_o,
    output unit_t           unit_q_o,
    output logic [3:0]      operation_q_o,
    output logic [XLEN-1:0] op1_q_o,
    output logic [XLEN-1:0] op2_q_o,
    output logic [XLEN-1:0] rs2_data_q_o,
    output logic [XLEN-1:0] imm_q_o,
    output logic [4:0]      rd_adr_q_o,
    output logic            rd_v_q_o,
    output logic            illegal_q_o
);

    localparam logic [1:0] BOOT_DONE = RESET_BUBBLES[1:0];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [1:0]      boot_cnt_q, boot_cnt_d;
    logic            valid_d;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, imm;
    logic [XLEN-1:0] op1_d, op2_d;
    imm_fmt_t        imm_fmt;
    op1_sel_t        op1_sel;
    op2_sel_t        op2_sel;
    unit_t           unit_dec, unit_d;
    logic [3:0]      oper_dec, oper_d;
    logic            rd_w, illegal;

    assign opcode = instr_q_i[6:0];
    assign rd     = instr_q_i[11:7];
    assign funct3 = instr_q_i[14:12];
    assign rs1    = instr_q_i[19:15];
    assign rs2    = instr_q_i[24:20];
    assign funct7 = instr_q_i[31:25];

    assign rf_adr1_o = rs1;
    assign rf_adr2_o = rs2;

    // x0 always reads zero; a same-cycle EXE write overrides the register file.
    assign rs1_fwd = (rs1 == 5'd0) ? '0 :
                     (exe_rd_v_i && exe_rd_adr_i == rs1) ? exe_rd_data_i : rf_data1_i;
    assign rs2_fwd = (rs2 == 5'd0) ? '0 :
                     (exe_rd_v_i && exe_rd_adr_i == rs2) ? exe_rd_data_i : rf_data2_i;

    // Startup counter: saturates once fetch delivers real instructions.
    assign boot_cnt_d = (boot_cnt_q == BOOT_DONE) ? boot_cnt_q : boot_cnt_q + 2'd1;
    // A redirect makes the word presented this cycle wrong-path.
    assign valid_d    = (boot_cnt_q == BOOT_DONE) && !branch_v_q_i && !exception_q_i;

    decode_imm u_imm (
        .instr_i (instr_q_i),
        .fmt_i   (imm_fmt),
        .imm_o   (imm)
    );

    // Classify the opcode: unit, operation, immediate format, operand sources, legality.
    always_comb begin
        unit_dec = UNIT_ALU;
        oper_dec = {1'b0, funct3};
        imm_fmt  = IMM_NONE;
        op1_sel  = OP1_RS1;
        op2_sel  = OP2_IMM;
        rd_w     = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                oper_dec = OPE_LUI;
                imm_fmt  = IMM_U;
                op1_sel  = OP1_ZERO;
                rd_w     = 1'b1;
            end
            OPC_AUIPC: begin
                oper_dec = OPE_AUIPC;
                imm_fmt  = IMM_U;
                op1_sel  = OP1_PC;
                rd_w     = 1'b1;
            end
            OPC_JAL: begin
                unit_dec = UNIT_BRU;
                oper_dec = OPE_JAL;
                imm_fmt  = IMM_J;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_FOUR;
                rd_w     = 1'b1;
            end
            OPC_JALR: begin
                unit_dec = UNIT_BRU;
                oper_dec = OPE_JALR;
                imm_fmt  = IMM_I;
                op2_sel  = OP2_FOUR;
                rd_w     = 1'b1;
            end
            OPC_BRANCH: begin
                unit_dec = UNIT_BRU;
                imm_fmt  = IMM_B;
                op2_sel  = OP2_RS2;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                unit_dec = UNIT_LSU;
                imm_fmt  = IMM_I;
                rd_w     = 1'b1;
                illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                unit_dec = UNIT_LSU;
                oper_dec = OPE_STORE_BIT | {1'b0, funct3};
                imm_fmt  = IMM_S;
                illegal  = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                imm_fmt  = IMM_I;
                rd_w     = 1'b1;
                // instr[30] selects SRAI only for shifts; elsewhere it is an immediate bit.
                if (funct3 == 3'b001) begin
                    oper_dec = {instr_q_i[30], funct3};
                    illegal  = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    oper_dec = {instr_q_i[30], funct3};
                    illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_OP: begin
                oper_dec = {instr_q_i[30], funct3};
                op2_sel  = OP2_RS2;
                rd_w     = 1'b1;
                illegal  = !((funct7 == 7'h00) ||
                             (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_FENCE: begin
                unit_dec = UNIT_SYS;
                oper_dec = OPE_FENCE;
                imm_fmt  = IMM_I;
            end
            OPC_SYSTEM: begin
                unit_dec = UNIT_SYS;
                imm_fmt  = IMM_I;
                oper_dec = (instr_q_i == INSTR_EBREAK) ? OPE_EBREAK : OPE_ECALL;
                illegal  = (instr_q_i != INSTR_ECALL) && (instr_q_i != INSTR_EBREAK);
            end
            default: illegal = 1'b1;
        endcase
        if (instr_q_i[1:0] != 2'b11) illegal = 1'b1;
    end

    // Build both operands and route illegal instructions to SYS.
    always_comb begin
        op1_d = rs1_fwd;
        op2_d = imm;
        case (op1_sel)
            OP1_PC:   op1_d = pc_q_i;
            OP1_ZERO: op1_d = '0;
            default:  op1_d = rs1_fwd;
        endcase
        case (op2_sel)
            OP2_RS2:  op2_d = rs2_fwd;
            OP2_FOUR: op2_d = 32'd4;
            default:  op2_d = imm;
        endcase
        unit_d = illegal ? UNIT_SYS : unit_dec;
        oper_d = illegal ? 4'd0 : oper_dec;
    end

    // Micro-op register and startup counter; no stall, every field flops each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boot_cnt_q    <= 2'd0;
            valid_q_o     <= 1'b0;
            pc_q_o        <= '0;
            unit_q_o      <= UNIT_ALU;
            operation_q_o <= 4'd0;
            op1_q_o       <= '0;
            op2_q_o       <= '0;
            rs2_data_q_o  <= '0;
            imm_q_o       <= '0;
            rd_adr_q_o    <= 5'd0;
            rd_v_q_o      <= 1'b0;
            illegal_q_o   <= 1'b0;
        end else begin
            boot_cnt_q    <= boot_cnt_d;
            valid_q_o     <= valid_d;
            pc_q_o        <= pc_q_i;
            unit_q_o      <= unit_d;
            operation_q_o <= oper_d;
            op1_q_o       <= op1_d;
            op2_q_o       <= op2_d;
            rs2_data_q_o  <= rs2_fwd;
            imm_q_o       <= imm;
            rd_adr_q_o    <= rd;
            rd_v_q_o      <= valid_d && rd_w && !illegal && (rd != 5'd0);
            illegal_q_o   <= valid_d && illegal;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for the decode stage against a behavioural
// model of the RV32I decode rules, plus directed cases for the key scenarios.
module tb_decode;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  unit;
        logic [3:0]  oper;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_v;
        logic        illegal;
    } uop_t;
    localparam int UOP_W = $bits(uop_t);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr_q_i = 32'h13, pc_q_i = '0;
    logic        branch_v_q_i = 1'b0, exception_q_i = 1'b0;
    logic [4:0]  rf_adr1_o, rf_adr2_o;
    logic [31:0] rf_data1_i = '0, rf_data2_i = '0;
    logic        exe_rd_v_i = 1'b0;
    logic [4:0]  exe_rd_adr_i = '0;
    logic [31:0] exe_rd_data_i = '0;
    logic        valid_q_o, rd_v_q_o, illegal_q_o;
    logic [31:0] pc_q_o, op1_q_o, op2_q_o, rs2_data_q_o, imm_q_o;
    unit_t       unit_q_o;
    logic [3:0]  operation_q_o;
    logic [4:0]  rd_adr_q_o;

    logic [UOP_W-1:0] exp_q[$];
    logic [31:0] rf[32];
    int n_total = 0;
    int n_bad = 0;
    int boot_edges = 0;

    decode dut (
        .clk(clk), .reset_n(reset_n), .instr_q_i(instr_q_i), .pc_q_i(pc_q_i),
        .branch_v_q_i(branch_v_q_i), .exception_q_i(exception_q_i),
        .rf_adr1_o(rf_adr1_o), .rf_adr2_o(rf_adr2_o),
        .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
        .exe_rd_v_i(exe_rd_v_i), .exe_rd_adr_i(exe_rd_adr_i), .exe_rd_data_i(exe_rd_data_i),
        .valid_q_o(valid_q_o), .pc_q_o(pc_q_o), .unit_q_o(unit_q_o),
        .operation_q_o(operation_q_o), .op1_q_o(op1_q_o), .op2_q_o(op2_q_o),
        .rs2_data_q_o(rs2_data_q_o), .imm_q_o(imm_q_o), .rd_adr_q_o(rd_adr_q_o),
        .rd_v_q_o(rd_v_q_o), .illegal_q_o(illegal_q_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Behavioural decode model, written from the instruction-set rules.
    function automatic uop_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic flush, input logic [31:0] d1, input logic [31:0] d2,
                                   input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                                   input int edges);
        uop_t u;
        logic signed [31:0] s;
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ill, writes;
        s  = ins;
        f3 = ins[14:12];
        f7 = ins[31:25];
        a  = (ins[19:15] == 0) ? 32'd0 : (ev && ea == ins[19:15]) ? ed : d1;
        b  = (ins[24:20] == 0) ? 32'd0 : (ev && ea == ins[24:20]) ? ed : d2;
        imm_i = 32'(s >>> 20);
        imm_s = 32'((s >>> 25) << 5) | 32'(ins[11:7]);
        imm_b = 32'((s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        imm_u = ins & 32'hFFFF_F000;
        imm_j = 32'((s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        u = '0;
        u.valid = (edges >= 2) && !flush;
        u.pc    = pc;
        u.rd    = ins[11:7];
        u.rs2d  = b;
        u.op1   = a;
        ill = 1'b0;
        writes = 1'b0;
        case (ins[6:0])
            7'b0110111: begin u.unit = 0; u.oper = OPE_LUI;   u.imm = imm_u; u.op1 = 0;  u.op2 = imm_u; writes = 1; end
            7'b0010111: begin u.unit = 0; u.oper = OPE_AUIPC; u.imm = imm_u; u.op1 = pc; u.op2 = imm_u; writes = 1; end
            7'b1101111: begin u.unit = 1; u.oper = OPE_JAL;   u.imm = imm_j; u.op1 = pc; u.op2 = 4; writes = 1; end
            7'b1100111: begin u.unit = 1; u.oper = OPE_JALR;  u.imm = imm_i; u.op2 = 4; writes = 1; end
            7'b1100011: begin u.unit = 1; u.oper = {1'b0, f3}; u.imm = imm_b; u.op2 = b; ill = (f3 == 2 || f3 == 3); end
            7'b0000011: begin u.unit = 2; u.oper = {1'b0, f3}; u.imm = imm_i; u.op2 = imm_i; writes = 1;
                              ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); end
            7'b0100011: begin u.unit = 2; u.oper = 4'd8 + 4'(f3); u.imm = imm_s; u.op2 = imm_s; ill = (f3 > 2); end
            7'b0010011: begin
                u.unit = 0; u.imm = imm_i; u.op2 = imm_i; writes = 1;
                if (f3 == 1 || f3 == 5) u.oper = {ins[30], f3}; else u.oper = {1'b0, f3};
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
            end
            7'b0110011: begin
                u.unit = 0; u.oper = {ins[30], f3}; u.imm = 0; u.op2 = b; writes = 1;
                ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'b0001111: begin u.unit = 3; u.oper = OPE_FENCE; u.imm = imm_i; u.op2 = imm_i; end
            7'b1110011: begin
                u.unit = 3; u.imm = imm_i; u.op2 = imm_i;
                u.oper = (ins == 32'h0010_0073) ? OPE_EBREAK : OPE_ECALL;
                ill = !(ins == 32'h0000_0073 || ins == 32'h0010_0073);
            end
            default: begin u.imm = 0; u.op2 = 0; ill = 1; end
        endcase
        if (ill) begin u.unit = 3; u.oper = 0; end
        u.illegal = u.valid && ill;
        u.rd_v    = u.valid && !ill && writes && (u.rd != 0);
        return u;
    endfunction

    // One cycle: drive at the falling edge, check after the rising edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic br,
                        input logic ex, input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        uop_t e;
        instr_q_i = ins; pc_q_i = pc; branch_v_q_i = br; exception_q_i = ex;
        exe_rd_v_i = ev; exe_rd_adr_i = ea; exe_rd_data_i = ed;
        rf_data1_i = rf[ins[19:15]];
        rf_data2_i = rf[ins[24:20]];
        #1;
        check("rf_adr1", 32'(rf_adr1_o), 32'(ins[19:15]));
        check("rf_adr2", 32'(rf_adr2_o), 32'(ins[24:20]));
        exp_q.push_back(model(ins, pc, br | ex, rf_data1_i, rf_data2_i, ev, ea, ed, boot_edges));
        @(posedge clk);
        #1;
        boot_edges++;
        e = uop_t'(exp_q.pop_front());
        check("valid",   32'(valid_q_o),     32'(e.valid));
        check("pc",      pc_q_o,             e.pc);
        check("unit",    32'(unit_q_o),      32'(e.unit));
        check("oper",    32'(operation_q_o), 32'(e.oper));
        check("op1",     op1_q_o,            e.op1);
        check("op2",     op2_q_o,            e.op2);
        check("rs2data", rs2_data_q_o,       e.rs2d);
        check("imm",     imm_q_o,            e.imm);
        check("rd_adr",  32'(rd_adr_q_o),    32'(e.rd));
        check("rd_v",    32'(rd_v_q_o),      32'(e.rd_v));
        check("illegal", 32'(illegal_q_o),   32'(e.illegal));
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_q_o), 0);
        check({tag, "_pc"}, pc_q_o, 0);
        check({tag, "_unit"}, 32'(unit_q_o), 0);
        check({tag, "_oper"}, 32'(operation_q_o), 0);
        check({tag, "_op1"}, op1_q_o, 0);
        check({tag, "_op2"}, op2_q_o, 0);
        check({tag, "_rs2"}, rs2_data_q_o, 0);
        check({tag, "_imm"}, imm_q_o, 0);
        check({tag, "_rd"}, 32'(rd_adr_q_o), 0);
        check({tag, "_rdv"}, 32'(rd_v_q_o), 0);
        check({tag, "_ill"}, 32'(illegal_q_o), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs[11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 15) < 13) begin
            w[6:0] = opcs[$urandom_range(0, 10)];
            if ((w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) && $urandom_range(0, 3) != 0)
                w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (w[6:0] == 7'b1110011 && $urandom_range(0, 2) != 0)
                w = $urandom_range(0, 1) ? 32'h0010_0073 : 32'h0000_0073;
        end
        return w;
    endfunction

    task automatic rand_step();
        logic [31:0] ins;
        logic [4:0] ea;
        ins = rand_instr();
        case ($urandom_range(0, 2))
            0: ea = ins[19:15];
            1: ea = ins[24:20];
            default: ea = 5'($urandom);
        endcase
        step(ins, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             1'($urandom), ea, $urandom);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        // Reset phase.
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        boot_edges = 0;

        // Startup bubbles with NOPs.
        step(32'h13, 32'h0, 0, 0, 0, 0, 0);
        check("boot0_v", 32'(valid_q_o), 0);
        step(32'h13, 32'h4, 0, 0, 0, 0, 0);
        check("boot1_v", 32'(valid_q_o), 0);
        step(32'h13, 32'h8, 0, 0, 0, 0, 0);
        check("boot2_v", 32'(valid_q_o), 1);

        // ADDI x5,x0,-1.
        step(32'hFFF0_0293, 32'h8000_0000, 0, 0, 0, 0, 0);
        check("addi_unit", 32'(unit_q_o), 0);
        check("addi_op1", op1_q_o, 0);
        check("addi_op2", op2_q_o, 32'hFFFF_FFFF);
        check("addi_rd", 32'(rd_adr_q_o), 5);
        check("addi_rdv", 32'(rd_v_q_o), 1);
        check("addi_pc", pc_q_o, 32'h8000_0000);

        // ADD x3,x1,x2 with forwarding on rs2, then from x0.
        rf[1] = 10; rf[2] = 20;
        step(32'h0020_81B3, 32'h100, 0, 0, 1, 2, 99);
        check("fwd_op1", op1_q_o, 10);
        check("fwd_op2", op2_q_o, 99);
        step(32'h0000_01B3, 32'h104, 0, 0, 1, 0, 99);
        check("x0_op1", op1_q_o, 0);
        check("x0_op2", op2_q_o, 0);

        // BEQ -8 and JAL x1,+2048.
        step(32'hFE00_0CE3, 32'h200, 0, 0, 0, 0, 0);
        check("beq_unit", 32'(unit_q_o), 1);
        check("beq_imm", imm_q_o, 32'hFFFF_FFF8);
        check("beq_rdv", 32'(rd_v_q_o), 0);
        step(32'h0010_00EF, 32'h300, 0, 0, 0, 0, 0);
        check("jal_op1", op1_q_o, 32'h300);
        check("jal_op2", op2_q_o, 4);
        check("jal_imm", imm_q_o, 32'h800);

        // Redirects kill exactly one instruction.
        step(32'h0020_81B3, 32'h400, 1, 0, 0, 0, 0);
        check("br_kill", 32'(valid_q_o), 0);
        step(32'h0020_81B3, 32'h404, 0, 0, 0, 0, 0);
        check("br_next", 32'(valid_q_o), 1);
        step(32'h0020_81B3, 32'h408, 0, 1, 0, 0, 0);
        check("ex_kill", 32'(valid_q_o), 0);
        step(32'h0020_81B3, 32'h40C, 0, 0, 0, 0, 0);
        check("ex_next", 32'(valid_q_o), 1);

        // Illegal encodings.
        step(32'h0000_0000, 32'h500, 0, 0, 0, 0, 0);
        check("ill0_v", 32'(valid_q_o), 1);
        check("ill0_i", 32'(illegal_q_o), 1);
        check("ill0_u", 32'(unit_q_o), 3);
        step(32'h0200_F0B3, 32'h504, 0, 0, 0, 0, 0);
        check("ill1_i", 32'(illegal_q_o), 1);
        check("ill1_u", 32'(unit_q_o), 3);
        check("ill1_rdv", 32'(rd_v_q_o), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) rand_step();

        // Asynchronous reset mid-cycle, then the startup bubbles again.
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        boot_edges = 0;
        for (int i = 0; i < 300; i++) rand_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout got=0 exp=1");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I decode stage, directly downstream of the fetch stage; consumes its flopped instruction/PC pair.
- Classifies the instruction, extracts the immediate and reads the register file.
- Selects operands with forwarding from EXE, kills wrong-path and startup instructions.
- Registers one decoded micro-op per cycle towards EXE.

Parameters:
- XLEN, 32 (from riscv_pkg), datapath and PC width.
- RESET_BUBBLES, 2, cycles after reset release during which incoming instructions are invalid.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- instr_q_i  in  32  instruction from fetch register
- pc_q_i  in  XLEN  PC of instr_q_i
- branch_v_q_i  in  1  EXE redirect (flopped)
- exception_q_i  in  1  EXE exception redirect (flopped)
- rf_adr1_o  out  5  rs1 read address (combinational)
- rf_adr2_o  out  5  rs2 read address (combinational)
- rf_data1_i  in  XLEN  rs1 read data, same cycle
- rf_data2_i  in  XLEN  rs2 read data, same cycle
- exe_rd_v_i  in  1  EXE result write valid
- exe_rd_adr_i  in  5  EXE result destination
- exe_rd_data_i  in  XLEN  EXE result value
- valid_q_o  out  1  micro-op valid
- pc_q_o  out  XLEN  PC of micro-op
- unit_q_o  out  unit_t  ALU/BRU/LSU/SYS
- operation_q_o  out  4  {instr[30], funct3}, or a package code for LUI/AUIPC/JAL/JALR/ECALL/EBREAK/FENCE
- op1_q_o  out  XLEN  operand 1
- op2_q_o  out  XLEN  operand 2
- rs2_data_q_o  out  XLEN  forwarded rs2 (store data, branch compare)
- imm_q_o  out  XLEN  sign-extended immediate
- rd_adr_q_o  out  5  destination register
- rd_v_q_o  out  1  writes rd
- illegal_q_o  out  1  illegal instruction, raised with valid

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low on reset_n. On reset every _q output is 0 (valid_q_o=0, unit_q_o=UNIT_ALU encoding 0) and the startup counter is 0.
- Startup: a 2-bit counter increments each cycle after reset release and saturates at RESET_BUBBLES. The incoming instruction is valid only when counter==RESET_BUBBLES. Fetch presents a zero/stale word during these cycles.
- Flush: if branch_v_q_i|exception_q_i in a cycle, the incoming instruction is wrong-path and valid_nxt=0. Only that one cycle is killed; the next input is the target instruction. The micro-op already in the output register is killed by EXE itself.
- Latency: 1 cycle; every _q output flops each cycle, with no stall or hold.
- Immediate formats: I, S, B, U and J, sign-extended per the RV32I format.
- Operand 1:
  - 0 for LUI.
  - pc for AUIPC/JAL.
  - otherwise forwarded rs1.
- Operand 2:
  - forwarded rs2 for OP/BRANCH.
  - 4 for JAL/JALR (link value).
  - imm otherwise.
- Register read: reads of x0 return 0 regardless of rf_data.
- Forwarding: if exe_rd_v_i && exe_rd_adr_i==rsN && rsN!=0, use exe_rd_data_i; otherwise use rf_data.
- rd_v: 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd!=0; 0 otherwise.
- Illegal when any of these holds:
  - instr[1:0]!=2'b11;
  - unknown opcode;
  - OP with funct7 not in {0x00,0x20}, or 0x20 with funct3 not ADD/SRL;
  - OP-IMM shift with bad funct7;
  - BRANCH funct3 010/011;
  - LOAD funct3 011/110/111;
  - STORE funct3>2;
  - SYSTEM other than ECALL/EBREAK.
- Illegal response: valid_q_o=1, illegal_q_o=1, rd_v_q_o=0, unit_q_o=SYS.
- Invalid micro-ops still flop their decode fields but force rd_v_q_o=0 and illegal_q_o=0.
- Reset mid-operation: all outputs return to 0 asynchronously and the startup counter restarts.

Decomposition:
- riscv_pkg gains:
  - unit_t enum {UNIT_ALU=0, UNIT_BRU, UNIT_LSU, UNIT_SYS};
  - opcode localparams (OPC_LUI=7'b0110111, ...);
  - operation codes OPE_LUI, OPE_AUIPC, OPE_JAL, OPE_JALR, OPE_ECALL, OPE_EBREAK, OPE_FENCE.
- One sub-module, decode_imm: combinational immediate extractor, instruction in, format-select in, XLEN immediate out.

Test Plan:
- Reset release, 0x00000013 presented every cycle -> valid_q_o=0 for the first 2 cycles after release, then 1. After the reset edge all outputs read 0.
- ADDI x5,x0,-1 (0xFFF00293) at pc 0x80000000 -> unit ALU, op1 0, op2 0xFFFFFFFF, rd_adr 5, rd_v 1, pc_q_o 0x80000000.
- ADD x3,x1,x2 with rf_data1=10, rf_data2=20, exe_rd_v=1, exe_rd_adr=2, exe_rd_data=99 -> op1 10, op2 99. The same stimulus with rs=x0 gives an operand of 0.
- BEQ with imm -8 (0xFE000CE3) -> unit BRU, imm_q_o 0xFFFFFFF8, rd_v 0. JAL x1,+2048 -> op1 pc, op2 4, imm 0x800.
- Valid ADD presented while branch_v_q_i=1 -> valid_q_o=0 next cycle; the following instruction is valid. Same check for exception_q_i.
- 0x00000000 and 0x0200F0B3 (funct7 0x01, OP) -> valid 1, illegal 1, unit SYS, rd_v 0.
